// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared binary16 parameters, enums and constants
package fp16_pkg;
   localparam int NE   = 5;
   localparam int NF   = 10;
   localparam int SW   = 3*NF + 4;
   localparam int BIAS = 15;
   // Internal exponent carries one extra bit beyond in_exp so normalize/round increments cannot wrap
   localparam int EW   = NE + 3;

   localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
   localparam logic signed [EW-1:0] EXP_INF = EW'((1 << NE) - 1);

   typedef enum logic [1:0] {
      RM_RZ  = 2'b00,
      RM_RNE = 2'b01,
      RM_RM  = 2'b10,
      RM_RP  = 2'b11
   } rmode_e;

   localparam int FLAG_NX  = 0;
   localparam int FLAG_UNF = 1;
   localparam int FLAG_OVF = 2;
   localparam int FLAG_INV = 3;

   localparam logic [15:0] QNAN16   = 16'h7E00;
   localparam logic [15:0] INF16    = 16'h7C00;
   localparam logic [15:0] MAXNUM16 = 16'h7BFF;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_NORM  = 2'b01,
      S_ROUND = 2'b10,
      S_DONE  = 2'b11
   } state_e;
endpackage

// File: rtl/fround16_rnd.sv
// rtl/fround16_rnd.sv - combinational round decision and binary16 pack
module fround16_rnd
   import fp16_pkg::*;
(
   input  logic                 i_sign,
   input  logic signed [EW-1:0] i_exp,
   input  logic [SW-1:0]        i_sig,
   input  logic                 i_sticky,
   input  logic                 i_nan,
   input  logic                 i_inf,
   input  logic                 i_invalid,
   input  rmode_e               i_rm,
   output logic [NE+NF:0]       o_result,
   output logic [3:0]           o_flags
);
   logic                 w_hidden;
   logic [NF-1:0]        w_frac;
   logic                 w_l;
   logic                 w_g;
   logic                 w_s;
   logic                 w_nx;
   logic                 w_up;
   logic [NF+1:0]        w_sum;
   logic signed [EW-1:0] w_exp_r;
   logic                 w_hid_r;
   logic [NF-1:0]        w_man_r;
   logic                 w_ovf;
   logic                 w_to_inf;
   logic [NE-1:0]        w_field;

   always_comb begin
      w_hidden = i_sig[SW-2];
      w_frac   = i_sig[SW-3 -: NF];
      w_l      = w_frac[0];
      w_g      = i_sig[SW-3-NF];
      w_s      = (|i_sig[SW-4-NF:0]) | i_sticky;
      w_nx     = w_g | w_s;
      unique case (i_rm)
         RM_RZ:  w_up = 1'b0;
         RM_RNE: w_up = w_g & (w_l | w_s);
         RM_RM:  w_up = i_sign & w_nx;
         RM_RP:  w_up = ~i_sign & w_nx;
      endcase
      w_sum = {1'b0, w_hidden, w_frac} + {{(NF+1){1'b0}}, w_up};
      // A carry past the hidden bit renormalizes to 1.0 with the next exponent
      if (w_sum[NF+1]) begin
         w_exp_r = i_exp + EXP_ONE;
         w_hid_r = 1'b1;
         w_man_r = '0;
      end else begin
         w_exp_r = i_exp;
         w_hid_r = w_sum[NF];
         w_man_r = w_sum[NF-1:0];
      end
      w_ovf    = w_hid_r && (w_exp_r >= EXP_INF);
      w_to_inf = (i_rm == RM_RNE) || (i_rm == RM_RP && !i_sign) || (i_rm == RM_RM && i_sign);
      w_field  = w_hid_r ? w_exp_r[NE-1:0] : '0;

      o_result           = {i_sign, w_field, w_man_r};
      o_flags            = '0;
      o_flags[FLAG_INV]  = i_invalid;
      o_flags[FLAG_NX]   = w_nx;
      o_flags[FLAG_UNF]  = (w_field == '0) && w_nx;
      if (w_ovf) begin
         o_result          = w_to_inf ? {i_sign, INF16[NE+NF-1:0]} : {i_sign, MAXNUM16[NE+NF-1:0]};
         o_flags[FLAG_OVF] = 1'b1;
         o_flags[FLAG_NX]  = 1'b1;
         o_flags[FLAG_UNF] = 1'b0;
      end
      if (i_inf) begin
         o_result = {i_sign, INF16[NE+NF-1:0]};
         o_flags  = {i_invalid, 3'b000};
      end
      if (i_nan) begin
         o_result = QNAN16;
         o_flags  = {i_invalid, 3'b000};
      end
   end
endmodule

// File: rtl/fround_pack16.sv
// rtl/fround_pack16.sv - iterative normalize/round/pack unit for binary16 results
module fround_pack16
   import fp16_pkg::*;
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_sign,
   input  logic [NE+1:0]   in_exp,
   input  logic [SW-1:0]   in_sig,
   input  logic            in_sticky,
   input  logic            in_nan,
   input  logic            in_inf,
   input  logic            in_invalid,
   input  logic [1:0]      roundmode,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [NE+NF:0]  result,
   output logic [3:0]      flags
);
   state_e               r_state;
   state_e               w_next;
   logic                 r_sign;
   logic signed [EW-1:0] r_exp;
   logic [SW-1:0]        r_sig;
   logic                 r_sticky;
   logic                 r_nan;
   logic                 r_inf;
   logic                 r_invalid;
   rmode_e               r_rm;
   logic [NE+NF:0]       r_result;
   logic [3:0]           r_flags;
   logic [NE+NF:0]       w_rnd_result;
   logic [3:0]           w_rnd_flags;
   logic                 w_zero;
   logic                 w_shr;
   logic                 w_shl;

   always_comb begin
      w_zero = (r_sig == '0) && !r_sticky;
      w_shr  = r_sig[SW-1] || (r_exp < EXP_ONE);
      w_shl  = !r_sig[SW-2] && (r_exp > EXP_ONE);
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (in_valid) w_next = (in_nan || in_inf) ? S_ROUND : S_NORM;
         S_NORM:  if (w_zero || !(w_shr || w_shl)) w_next = S_ROUND;
         S_ROUND: w_next = S_DONE;
         S_DONE:  if (out_ready) w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_sign    <= 1'b0;
         r_exp     <= '0;
         r_sig     <= '0;
         r_sticky  <= 1'b0;
         r_nan     <= 1'b0;
         r_inf     <= 1'b0;
         r_invalid <= 1'b0;
         r_rm      <= RM_RZ;
         r_result  <= '0;
         r_flags   <= '0;
      end else begin
         r_state <= w_next;
         unique case (r_state)
            S_IDLE: if (in_valid) begin
               r_sign    <= in_sign;
               r_exp     <= {in_exp[NE+1], in_exp};
               r_sig     <= in_sig;
               r_sticky  <= in_sticky;
               r_nan     <= in_nan;
               r_inf     <= in_inf;
               r_invalid <= in_invalid;
               r_rm      <= rmode_e'(roundmode);
            end
            S_NORM: if (!w_zero) begin
               if (w_shr) begin
                  r_sig    <= r_sig >> 1;
                  r_sticky <= r_sticky | r_sig[0];
                  // Everything shifted out: park at the subnormal exponent and stop
                  r_exp    <= (r_sig[SW-1:1] == '0) ? EXP_ONE : r_exp + EXP_ONE;
               end else if (w_shl) begin
                  r_sig <= r_sig << 1;
                  r_exp <= r_exp - EXP_ONE;
               end
            end
            S_ROUND: begin
               r_result <= w_rnd_result;
               r_flags  <= w_rnd_flags;
            end
            S_DONE: ;
         endcase
      end
   end

   fround16_rnd u_rnd (
      .i_sign    (r_sign),
      .i_exp     (r_exp),
      .i_sig     (r_sig),
      .i_sticky  (r_sticky),
      .i_nan     (r_nan),
      .i_inf     (r_inf),
      .i_invalid (r_invalid),
      .i_rm      (r_rm),
      .o_result  (w_rnd_result),
      .o_flags   (w_rnd_flags)
   );

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign result    = r_result;
   assign flags     = r_flags;
endmodule
